// File: rtl/mc_alu_pkg.sv
// rtl/mc_alu_pkg.sv - shared op codes, FSM states and shift modes for mc_alu
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_RETA = 4'd6,
    OP_RETB = 4'd7,
    OP_EQU  = 4'd8,
    OP_SLL  = 4'd9,
    OP_SLLV = 4'd10,
    OP_SRA  = 4'd11,
    OP_SRL  = 4'd12,
    OP_MUL  = 4'd13,
    OP_NOP  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SH_LEFT        = 2'd0,
    SH_RIGHT_LOGIC = 2'd1,
    SH_RIGHT_ARITH = 2'd2
  } sh_mode_e;

endpackage

// File: rtl/mc_alu_shifter.sv
// rtl/mc_alu_shifter.sv - one-bit-per-cycle shift register with down-counter
module mc_alu_shifter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  sh_mode_e         i_mode,
  input  logic [WIDTH-1:0] i_value,
  input  logic [SHW-1:0]   i_amt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done
);

  logic [WIDTH-1:0] r_val;
  logic [SHW-1:0]   r_cnt;
  sh_mode_e         r_mode;
  logic [WIDTH-1:0] w_step;

  always_comb begin
    w_step = r_val;
    case (r_mode)
      SH_LEFT:        w_step = {r_val[WIDTH-2:0], 1'b0};
      SH_RIGHT_LOGIC: w_step = {1'b0, r_val[WIDTH-1:1]};
      default:        w_step = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
    endcase
  end

  // o_result is the value after this cycle's step; o_done marks the final step
  assign o_result = w_step;
  assign o_done   = (r_cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val  <= '0;
      r_cnt  <= '0;
      r_mode <= SH_LEFT;
    end else if (i_load) begin
      r_val  <= i_value;
      r_cnt  <= i_amt;
      r_mode <= i_mode;
    end else if (r_cnt != '0) begin
      r_val <= w_step;
      r_cnt <= r_cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU with valid/ready handshakes
// Define MC_ALU_MUL_EN to build the shift-add MUL op; otherwise MUL acts as NOP.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int             M    = WIDTH - 1;
  localparam logic [SHW-1:0] HALF = SHW'(WIDTH / 2);

  state_e           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_zero, r_carry, r_ovf;

  op_e              w_op;
  logic             w_accept;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_y;
  logic             w_carry, w_ovf, w_is_shift;
  sh_mode_e         w_mode;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_sh_result;
  logic             w_sh_done;
`ifdef MC_ALU_MUL_EN
  logic               w_is_mul;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_mcnt;
`endif

  assign w_op      = op_e'(op);
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_y;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

  // amount 0 means half-width for SLL/SRL/SRA but a true zero for SLLV
  assign w_amt = (a[SHW-1:0] == '0 && w_op != OP_SLLV) ? HALF : a[SHW-1:0];

  always_comb begin
    w_sum      = {1'b0, a} + {1'b0, b};
    w_diff     = {1'b0, a} - {1'b0, b};
    w_y        = r_y;
    w_carry    = 1'b0;
    w_ovf      = 1'b0;
    w_is_shift = 1'b0;
    w_mode     = SH_LEFT;
`ifdef MC_ALU_MUL_EN
    w_is_mul   = 1'b0;
`endif
    case (w_op)
      OP_ADD: begin
        w_y     = w_sum[M:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[M] == b[M]) && (w_sum[M] != a[M]);
      end
      OP_SUB: begin
        w_y     = w_diff[M:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[M] != b[M]) && (w_diff[M] != a[M]);
      end
      OP_AND:  w_y = a & b;
      OP_OR:   w_y = a | b;
      OP_XOR:  w_y = a ^ b;
      OP_NOT:  w_y = ~a;
      OP_RETA: w_y = a;
      OP_RETB: w_y = b;
      OP_EQU:  w_y = (a == b) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
      OP_SLL, OP_SLLV: w_is_shift = 1'b1;
      OP_SRL: begin
        w_is_shift = 1'b1;
        w_mode     = SH_RIGHT_LOGIC;
      end
      OP_SRA: begin
        w_is_shift = 1'b1;
        w_mode     = SH_RIGHT_ARITH;
      end
`ifdef MC_ALU_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  mc_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept && w_is_shift),
    .i_mode   (w_mode),
    .i_value  (b),
    .i_amt    (w_amt),
    .o_result (w_sh_result),
    .o_done   (w_sh_done)
  );

`ifdef MC_ALU_MUL_EN
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_mcnt   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, b};
      r_mplier <= a;
      r_mcnt   <= SHW'(WIDTH - 1);
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[M:1]};
      r_mcnt   <= r_mcnt - SHW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_zero  <= (a == '0);
          r_carry <= w_carry;
          r_ovf   <= w_ovf;
          if (w_is_shift) begin
            if (w_amt == '0) begin
              r_y     <= b;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
`ifdef MC_ALU_MUL_EN
          else if (w_is_mul) begin
            r_state <= ST_MUL;
          end
`endif
          else begin
            r_y     <= w_y;
            r_state <= ST_DONE;
          end
        end
        ST_SHIFT: if (w_sh_done) begin
          r_y     <= w_sh_result;
          r_state <= ST_DONE;
        end
`ifdef MC_ALU_MUL_EN
        ST_MUL: if (r_mcnt == '0) begin
          r_y     <= w_acc_next[M:0];
          r_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed vector bench for mc_alu (WIDTH=16)
module tb_mc_alu;
  import mc_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic [3:0]   op;
  logic         zero, carry, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, y;
    logic         c, v, z;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] o, input logic [W-1:0] aa, bb, yy,
                              input logic cc, vv, zz, input int ll);
    vec_t t;
    t.op = o; t.a = aa; t.b = bb; t.y = yy; t.c = cc; t.v = vv; t.z = zz; t.lat = ll;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one triple, return cycles from accept until out_valid (capped at 60)
  task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, bb, output int lat);
    @(negedge clk);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 60);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic seen;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_y", y, 0);
    check("reset_flags", {zero, carry, ovf}, 0);

    //   op       a        b        y        c  v  z  lat
    add(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
    add(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 1);
    add(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 1);
    add(OP_SUB,  16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 1);
    add(OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 1);
    add(OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 0, 0, 0, 1);
    add(OP_XOR,  16'hAAAA, 16'hFFFF, 16'h5555, 0, 0, 0, 1);
    add(OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 0, 0, 0, 1);
    add(OP_RETA, 16'h1234, 16'h5678, 16'h1234, 0, 0, 0, 1);
    add(OP_RETB, 16'h1234, 16'h5678, 16'h5678, 0, 0, 0, 1);
    add(OP_EQU,  16'h1234, 16'h1234, 16'h0000, 0, 0, 0, 1);
    add(OP_EQU,  16'h0001, 16'h0002, 16'h0001, 0, 0, 0, 1);
    add(OP_SRA,  16'h0000, 16'h8000, 16'hFF80, 0, 0, 1, 9);
    add(OP_SLLV, 16'h0000, 16'h0005, 16'h0005, 0, 0, 1, 1);
    add(OP_SLL,  16'h0003, 16'h0001, 16'h0008, 0, 0, 0, 4);
    add(OP_SRL,  16'h0004, 16'h8000, 16'h0800, 0, 0, 0, 5);
    add(OP_SRA,  16'h0001, 16'h8001, 16'hC000, 0, 0, 0, 2);
    add(OP_SLL,  16'h0000, 16'h0001, 16'h0100, 0, 0, 1, 9);
    add(OP_SLLV, 16'h0002, 16'h0003, 16'h000C, 0, 0, 0, 3);
    add(OP_SRL,  16'h0013, 16'h0080, 16'h0010, 0, 0, 0, 4);
    add(OP_NOP,  16'h0000, 16'hBEEF, 16'h0010, 0, 0, 1, 1);
    add(4'd14,   16'h0005, 16'hBEEF, 16'h0010, 0, 0, 0, 1);
`ifdef MC_ALU_MUL_EN
    add(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1, 0, 0, 17);
    add(OP_MUL,  16'h0003, 16'h0005, 16'h000F, 0, 0, 0, 17);
    add(OP_MUL,  16'h00FF, 16'h0101, 16'hFFFF, 0, 0, 0, 17);
`else
    add(OP_MUL,  16'h0100, 16'h0100, 16'h0010, 0, 0, 0, 1);
    add(OP_MUL,  16'h0003, 16'h0005, 16'h0010, 0, 0, 0, 1);
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_y", i), y, vecs[i].y);
      check($sformatf("vec%0d_czv", i), {carry, zero, ovf}, {vecs[i].c, vecs[i].z, vecs[i].v});
      handoff();
    end

    // SUB 0-1 held in DONE for 5 cycles while a busy in_valid is ignored
    issue(OP_SUB, 16'h0000, 16'h0001, lat);
    check("hold_latency", lat, 1);
    in_valid = 1'b1; op = OP_ADD; a = 16'h5555; b = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d", k), {out_valid, in_ready, y, carry, zero, ovf},
            {1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    handoff();

    // busy in_valid during SHIFT must not disturb the running shift
    @(negedge clk);
    op = OP_SLL; a = 16'h0002; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk);
    #1 op = OP_RETA; a = 16'hFFFF; b = 16'hFFFF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (out_valid) in_valid = 1'b0;
    end while (!out_valid && lat < 60);
    in_valid = 1'b0;
    check("busy_shift_latency", lat, 3);
    check("busy_shift_y", y, 16'h0004);
    handoff();
    @(negedge clk);
    check("busy_no_extra_op", out_valid, 0);

    // reset on the 3rd cycle of SLL a=6 discards the op
    @(negedge clk);
    op = OP_SLL; a = 16'h0006; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("async_reset_y", y, 0);
    check("async_reset_out_valid", out_valid, 0);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("reset_discard_no_out_valid", seen, 0);
    check("reset_release_in_ready", in_ready, 1);
    check("reset_release_y", y, 0);

    issue(OP_RETB, 16'h0000, 16'h00AA, lat);
    check("post_reset_latency", lat, 1);
    check("post_reset_y", y, 16'h00AA);
    handoff();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits; legal range 8..32; must be a power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from a.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, the operand/op triple is valid this cycle.
REQ-006 Port in_ready, output, 1, the block accepts a triple this cycle.
REQ-007 Port a, input, WIDTH, operand A; also the shift amount for shift ops.
REQ-008 Port b, input, WIDTH, operand B; the shifted value for shift ops.
REQ-009 Port op, input, 4, operation code from the shared package.
REQ-010 Port out_valid, output, 1, y and the flags hold a completed result.
REQ-011 Port out_ready, input, 1, the consumer takes the result this cycle.
REQ-012 Port y, output, WIDTH, result.
REQ-013 Port zero, output, 1, set when the captured a of the op equals 0.
REQ-014 Port carry, output, 1, carry-out for ADD and borrow for SUB; 0 for all other ops.
REQ-015 Port ovf, output, 1, signed overflow for ADD/SUB; 0 for all other ops.

Function
REQ-016 The FSM shall have states IDLE, SHIFT, MUL and DONE; in_ready shall be 1 only in IDLE.
REQ-017 Accept: a transfer occurs when in_valid && in_ready; a, b and op are captured into registers at that edge.
REQ-018 The single-cycle ops (ADD, SUB, AND, OR, XOR, NOT(~a), RETA, RETB, EQU, NOP) shall go IDLE->DONE, with out_valid asserted the cycle after accept.
REQ-019 EQU shall give y = 0 when a==b and y = 1 otherwise.
REQ-020 NOP shall leave y unchanged, with carry=0 and ovf=0.
REQ-021 Shift amount: amt = a[SHW-1:0].
- SLL, SRL and SRA treat amt==0 as WIDTH/2.
- SLLV treats amt==0 as 0.
REQ-022 Shifts shall move one bit per cycle in SHIFT, loading a down-counter with the effective amount.
- Effective amount 0 goes straight to DONE.
- Latency from accept to out_valid = effective amount + 1 cycles.
REQ-023 SRA shall replicate b[WIDTH-1]; SRL shall fill with 0.
REQ-024 In DONE, out_valid=1 and y and the flags shall be held stable until out_ready; on out_valid && out_ready the FSM goes to IDLE.
REQ-025 There shall be no accept in the handoff cycle: throughput is at most one op per two cycles.
REQ-026 An op code not in the package shall behave as NOP.
REQ-027 in_valid while busy shall be ignored, and the operands shall not be sampled.

Reset
REQ-028 On rst low, asynchronously:
- state = IDLE;
- y, zero, carry, ovf and out_valid = 0;
- in_ready = 1 after rst releases.
REQ-029 Reset during SHIFT, MUL or DONE shall discard the op, and no out_valid shall follow.

Configuration
REQ-030 Macro MC_ALU_MUL_EN defined: op MUL is supported.
- Unsigned shift-add, one partial product per cycle, WIDTH cycles in MUL.
- y = low WIDTH bits of a*b.
- carry = OR of the high WIDTH bits.
- Latency = WIDTH + 1.
REQ-031 Macro MC_ALU_MUL_EN undefined: MUL shall behave as NOP, and no MUL state or multiplier logic shall be present.

Structure
REQ-032 Package mc_alu_pkg shall hold the op enum and the FSM state enum.
- Op enum, 4-bit: ADD=0, SUB, AND, OR, XOR, NOT, RETA, RETB, EQU, SLL, SLLV, SRA, SRL, MUL, NOP=15.
- FSM state enum: IDLE, SHIFT, MUL, DONE.
REQ-033 Sub-module mc_alu_shifter: a one-bit-per-step shift register with counter, done pulse and a mode input (SLL/SRL/SRA).

Verification (WIDTH=16)
REQ-034 ADD a=16'h7FFF, b=1 -> one cycle after accept: y=16'h8000, ovf=1, carry=0, zero=0.
REQ-035 SRA a=0, b=16'h8000 -> out_valid 9 cycles after accept, y=16'hFF80; SLLV a=0, b=5 -> y=5 after 1 cycle.
REQ-036 SUB a=0, b=1 with out_ready held low for 5 cycles -> y=16'hFFFF, carry=1, zero=1, all stable; in_ready=0 throughout.
REQ-037 Reset asserted on the 3rd cycle of SLL a=6 -> out_valid never rises; after release in_ready=1 and y=0.
REQ-038 MUL a=16'h0100, b=16'h0100 with MC_ALU_MUL_EN -> y=0, carry=1 after 17 cycles; without the macro -> y is unchanged after 1 cycle.
